fir_coeff_loader: RTL and testbench
===================================

# fir_coeff_loader

Coefficient writer for the 8-tap FIR datapath: accepts a serial stream of signed coefficients over a valid/ready handshake, assembles a complete set in a shadow bank, and atomically publishes it on the packed coefficient bus the filter reads. A partially loaded or malformed set is never visible to the filter. The block sits between the control/configuration path and the filter's packed coefficient input.

## Interface
- DATA_WIDTH, 16, coefficient width in bits (signed two's complement)
- NUM_TAPS, 8, coefficients per set; legal range 2..64

- clk  in  1  clock, all logic rising-edge
- reset  in  1  synchronous, active-high
- coeff_valid  in  1  coeff_data/coeff_last valid this cycle
- coeff_ready  out  1  loader can accept a beat this cycle
- coeff_data  in  DATA_WIDTH  coefficient; tap 0 first
- coeff_last  in  1  marks final beat of a set
- commit_hold  in  1  while high, publishing of a completed set is deferred
- fir_coeffs  out  DATA_WIDTH*NUM_TAPS  active set; tap k at [k*DATA_WIDTH +: DATA_WIDTH]
- coeff_updated  out  1  one-cycle pulse when fir_coeffs changes
- err_short  out  1  one-cycle pulse: set ended with fewer than NUM_TAPS beats
- err_long  out  1  one-cycle pulse: set exceeded NUM_TAPS beats
- sets_committed  out  8  count of published sets, wraps 255->0

## Operation
- Beat accepted when coeff_valid && coeff_ready. coeff_data/coeff_last ignored otherwise.
- Tap index counter idx (clog2(NUM_TAPS) bits) addresses shadow bank; shadow written only on accepted beats.
- States:
  - IDLE: coeff_ready=1. Accepted beat -> shadow[0], idx=1. If coeff_last -> err_short, stay IDLE; else -> LOAD.
  - LOAD: coeff_ready=1. Accepted beat -> shadow[idx]. If idx==NUM_TAPS-1: coeff_last -> COMMIT; not last -> DRAIN. If idx<NUM_TAPS-1: coeff_last -> err_short, IDLE; else idx++.
  - DRAIN: coeff_ready=1; accepted beats discarded; on accepted coeff_last -> err_long, IDLE.
  - COMMIT: coeff_ready=0. If commit_hold low: fir_coeffs <= shadow, coeff_updated, sets_committed++, -> IDLE. If high: remain.
- Errors leave fir_coeffs and sets_committed unchanged; shadow contents after an error are don't-care (next set overwrites all taps).
- Publish is atomic: all NUM_TAPS fields of fir_coeffs change on the same edge.
- Reset: state IDLE, idx 0, shadow 0, all outputs 0 except coeff_ready. Reset mid-set discards the set; mid-COMMIT discards the pending publish.

## Timing
- coeff_ready decoded from registered state only (no combinational path from coeff_valid); 0 while reset asserted, 1 the first cycle after reset deasserts.
- Back-to-back beats at one per cycle, no bubbles, in IDLE/LOAD/DRAIN.
- Last beat accepted at edge N -> COMMIT during cycle N..N+1 -> fir_coeffs, coeff_updated, sets_committed update at edge N+1 (commit_hold low). Each held cycle adds one cycle.
- Exactly one non-accepting cycle (COMMIT) between sets with commit_hold low; a new set may start the cycle after publish.
- err_short/err_long registered: high for the single cycle after the edge accepting the offending coeff_last.
- coeff_updated, err_short, err_long mutually exclusive.

## Test plan
- Reset, then send taps 1,2,..,8 (last on 8) at one beat/cycle -> coeff_ready low exactly one cycle, fir_coeffs = {8,7,..,1} packed (tap 0 = 1), coeff_updated one cycle, sets_committed=1, 2 cycles after first beat's acceptance + 7.
- Send 5 beats with last on 5th after an existing set -> err_short pulse, fir_coeffs unchanged, coeff_ready stays high; following valid 8-beat set publishes normally.
- Send 10 beats, last on 10th -> err_long pulse on cycle after 10th, no coeff_updated, sets_committed unchanged; single-beat set with last -> err_short.
- Complete set with commit_hold high 4 cycles -> coeff_ready low 5 cycles, fir_coeffs unchanged until hold drops, then updated with one coeff_updated pulse; toggle coeff_valid randomly -> identical result.
- Assert reset after 4 beats of a set and during a held COMMIT -> fir_coeffs=0, sets_committed=0, no pulses; next full set publishes.
- Publish 256 sets of -32768 and 32767 alternating -> sign preserved in every field, sets_committed wraps to 0.

Source files
------------

// File: rtl/fir_coeff_loader.sv
// Shadow-bank coefficient loader for the FIR filter: streams a full set of taps in,
// then publishes all of them to the packed coefficient bus on a single edge.
module fir_coeff_loader #(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_TAPS   = 8
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           coeff_valid,
    output logic                           coeff_ready,
    input  logic [DATA_WIDTH-1:0]          coeff_data,
    input  logic                           coeff_last,
    input  logic                           commit_hold,
    output logic [DATA_WIDTH*NUM_TAPS-1:0] fir_coeffs,
    output logic                           coeff_updated,
    output logic                           err_short,
    output logic                           err_long,
    output logic [7:0]                     sets_committed
);

    localparam int IDX_W = (NUM_TAPS > 1) ? $clog2(NUM_TAPS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        DRAIN  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [IDX_W-1:0]        idx_r;
    logic [IDX_W-1:0]        idx_s;
    logic [IDX_W-1:0]        wr_idx_s;
    logic                    shadow_we_s;
    logic                    err_short_s;
    logic                    err_long_s;
    logic                    publish_s;
    logic                    accept_s;
    logic [DATA_WIDTH-1:0]   shadow_r [NUM_TAPS];

    assign accept_s = coeff_valid && coeff_ready;

    // State and tap index registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
            idx_r   <= '0;
        end else begin
            state_r <= state_s;
            idx_r   <= idx_s;
        end
    end

    // Next-state decode and per-beat control strobes
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        wr_idx_s    = idx_r;
        shadow_we_s = 1'b0;
        err_short_s = 1'b0;
        err_long_s  = 1'b0;
        publish_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    shadow_we_s = 1'b1;
                    wr_idx_s    = '0;
                    idx_s       = IDX_W'(1);
                    if (coeff_last) begin
                        err_short_s = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        state_s     = LOAD;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD: begin
                if (accept_s) begin
                    shadow_we_s = 1'b1;
                    if (idx_r == LAST_IDX) begin
                        state_s = coeff_last ? COMMIT : DRAIN;
                    end else if (coeff_last) begin
                        err_short_s = 1'b1;
                        state_s     = IDLE;
                    end else begin
                        idx_s = idx_r + IDX_W'(1);
                    end
                end else begin
                    state_s = LOAD;
                end
            end
            DRAIN: begin
                // Surplus beats are swallowed until the sender closes the set
                if (accept_s && coeff_last) begin
                    err_long_s = 1'b1;
                    state_s    = IDLE;
                end else begin
                    state_s = DRAIN;
                end
            end
            COMMIT: begin
                if (!commit_hold) begin
                    publish_s = 1'b1;
                    state_s   = IDLE;
                end else begin
                    state_s = COMMIT;
                end
            end
            default: begin
                state_s = IDLE;
                idx_s   = '0;
            end
        endcase
    end

    // Ready is registered from the next state so it never depends on coeff_valid
    always_ff @(posedge clk) begin
        if (reset) begin
            coeff_ready <= 1'b0;
        end else begin
            coeff_ready <= (state_s != COMMIT);
        end
    end

    // Shadow bank, published coefficient bus, status pulses and set counter
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_TAPS; k++) begin
                shadow_r[k] <= '0;
            end
            fir_coeffs     <= '0;
            coeff_updated  <= 1'b0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
            sets_committed <= 8'd0;
        end else begin
            if (shadow_we_s) begin
                shadow_r[wr_idx_s] <= coeff_data;
            end
            if (publish_s) begin
                for (int k = 0; k < NUM_TAPS; k++) begin
                    fir_coeffs[k*DATA_WIDTH +: DATA_WIDTH] <= shadow_r[k];
                end
                sets_committed <= sets_committed + 8'd1;
            end
            coeff_updated <= publish_s;
            err_short     <= err_short_s;
            err_long      <= err_long_s;
        end
    end

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Scoreboard bench for fir_coeff_loader: expected publishes and error pulses are
// queued as sets are driven and matched when the loader reports them.
module tb_fir_coeff_loader;

    localparam int DW = 16;
    localparam int NT = 8;
    localparam int W  = DW * NT;

    logic          clk;
    logic          reset;
    logic          coeff_valid;
    logic          coeff_ready;
    logic [DW-1:0] coeff_data;
    logic          coeff_last;
    logic          commit_hold;
    logic [W-1:0]  fir_coeffs;
    logic          coeff_updated;
    logic          err_short;
    logic          err_long;
    logic [7:0]    sets_committed;

    int            n_checks;
    int            n_errors;
    logic [W-1:0]  pub_q[$];
    logic [7:0]    cnt_q[$];
    int            err_q[$];
    logic [DW-1:0] beat_q[$];
    logic [7:0]    exp_sets;
    logic [W-1:0]  exp_fir;
    logic [W-1:0]  last_fir;

    fir_coeff_loader #(.DATA_WIDTH(DW), .NUM_TAPS(NT)) dut (
        .clk(clk), .reset(reset), .coeff_valid(coeff_valid), .coeff_ready(coeff_ready),
        .coeff_data(coeff_data), .coeff_last(coeff_last), .commit_hold(commit_hold),
        .fir_coeffs(fir_coeffs), .coeff_updated(coeff_updated), .err_short(err_short),
        .err_long(err_long), .sets_committed(sets_committed)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Queue expectations from the beats in beat_q, then drive them with retry on !ready
    task automatic send(input bit with_last, input bit rnd);
        int n;
        int i;
        int guard;
        bit v;
        bit acc;
        logic [W-1:0] packed_v;
        n = beat_q.size();
        if (with_last) begin
            if (n == NT) begin
                packed_v = '0;
                for (int k = 0; k < NT; k++) packed_v[k*DW +: DW] = beat_q[k];
                exp_sets = exp_sets + 8'd1;
                pub_q.push_back(packed_v);
                cnt_q.push_back(exp_sets);
            end else begin
                err_q.push_back((n < NT) ? 1 : 2);
            end
        end
        i = 0;
        guard = 0;
        while (i < n && guard < 1000) begin
            @(negedge clk);
            guard++;
            v = rnd ? 1'($urandom_range(1, 0)) : 1'b1;
            coeff_valid = v;
            coeff_data  = beat_q[i];
            coeff_last  = with_last && (i == n - 1);
            acc = v && coeff_ready;
            @(posedge clk);
            if (acc) i++;
        end
        #1;
        coeff_valid = 1'b0;
        coeff_last  = 1'b0;
        check("send_timeout", W'(i), W'(n));
    endtask

    task automatic fill_seq(input int n, input int base);
        beat_q.delete();
        for (int k = 0; k < n; k++) beat_q.push_back(DW'(base + k));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        coeff_valid = 1'b0;
        coeff_last = 1'b0;
        commit_hold = 1'b0;
        pub_q.delete();
        cnt_q.delete();
        err_q.delete();
        exp_sets = 8'd0;
        repeat (2) @(negedge clk);
        check("ready_in_reset", W'(coeff_ready), W'(0));
        reset = 1'b0;
        @(negedge clk);
        check("ready_after_reset", W'(coeff_ready), W'(1));
        check("fir_after_reset", fir_coeffs, '0);
        check("sets_after_reset", W'(sets_committed), W'(0));
        check("upd_after_reset", W'(coeff_updated), W'(0));
    endtask

    // Output monitor: every pulse must match a queued expectation
    always @(negedge clk) begin
        if (reset === 1'b0) begin
            check("pulse_exclusive", W'(int'(coeff_updated) + int'(err_short) + int'(err_long) <= 1), W'(1));
            if (coeff_updated === 1'b1) begin
                if (pub_q.size() == 0) begin
                    check("unexpected_update", W'(1), W'(0));
                end else begin
                    check("publish_fir", fir_coeffs, pub_q.pop_front());
                    check("publish_count", W'(sets_committed), W'(cnt_q.pop_front()));
                end
            end
            if (err_short === 1'b1 || err_long === 1'b1) begin
                if (err_q.size() == 0) begin
                    check("unexpected_error", W'(1), W'(0));
                end else begin
                    check("error_kind", W'(err_short ? 1 : 2), W'(err_q.pop_front()));
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        exp_sets = 8'd0;
        reset = 1'b1;
        coeff_valid = 1'b0;
        coeff_data = '0;
        coeff_last = 1'b0;
        commit_hold = 1'b0;
        do_reset();

        // Basic set 1..8, one beat per cycle
        fill_seq(NT, 1);
        send(1'b1, 1'b0);
        @(negedge clk);
        check("commit_ready_low", W'(coeff_ready), W'(0));
        check("commit_no_update", W'(coeff_updated), W'(0));
        check("commit_fir_old", fir_coeffs, '0);
        @(negedge clk);
        check("post_ready_high", W'(coeff_ready), W'(1));
        check("post_updated", W'(coeff_updated), W'(1));
        check("post_fir", fir_coeffs, 128'h0008_0007_0006_0005_0004_0003_0002_0001);
        check("post_sets", W'(sets_committed), W'(1));
        repeat (2) @(negedge clk);

        // Short set leaves the bus alone, then a good set publishes
        last_fir = fir_coeffs;
        fill_seq(5, 100);
        send(1'b1, 1'b0);
        @(negedge clk);
        check("short_pulse", W'(err_short), W'(1));
        check("short_ready", W'(coeff_ready), W'(1));
        check("short_fir", fir_coeffs, last_fir);
        fill_seq(NT, 16'h0200);
        send(1'b1, 1'b0);
        repeat (3) @(negedge clk);

        // Long set, then a single-beat set
        last_fir = fir_coeffs;
        fill_seq(10, 16'h0300);
        send(1'b1, 1'b0);
        @(negedge clk);
        check("long_pulse", W'(err_long), W'(1));
        check("long_no_update", W'(coeff_updated), W'(0));
        check("long_sets", W'(sets_committed), W'(2));
        check("long_fir", fir_coeffs, last_fir);
        fill_seq(1, 16'h0400);
        send(1'b1, 1'b0);
        @(negedge clk);
        check("single_short", W'(err_short), W'(1));

        // Held commit, first with steady valid then with random valid
        for (int pass = 0; pass < 2; pass++) begin
            last_fir = fir_coeffs;
            commit_hold = 1'b1;
            fill_seq(NT, 16'hF000 + pass * 16);
            send(1'b1, pass == 1);
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                check("hold_ready_low", W'(coeff_ready), W'(0));
                check("hold_fir_same", fir_coeffs, last_fir);
                if (k == 4) commit_hold = 1'b0;
            end
            @(negedge clk);
            check("hold_release_upd", W'(coeff_updated), W'(1));
            check("hold_release_ready", W'(coeff_ready), W'(1));
            @(negedge clk);
        end

        // Reset mid-set and during a held commit
        fill_seq(4, 16'h0500);
        send(1'b0, 1'b0);
        do_reset();
        commit_hold = 1'b1;
        fill_seq(NT, 16'h0600);
        send(1'b1, 1'b0);
        repeat (2) @(negedge clk);
        do_reset();
        fill_seq(NT, 16'h0700);
        send(1'b1, 1'b0);
        repeat (3) @(negedge clk);
        check("after_reset_sets", W'(sets_committed), W'(1));

        // 256 sets of extreme values; counter wraps back to 0
        do_reset();
        for (int j = 0; j < 256; j++) begin
            beat_q.delete();
            for (int k = 0; k < NT; k++) beat_q.push_back(((j + k) % 2) ? 16'h7FFF : 16'h8000);
            send(1'b1, 1'b0);
        end
        repeat (3) @(negedge clk);
        check("wrap_sets", W'(sets_committed), W'(0));
        exp_fir = '0;
        for (int k = 0; k < NT; k++) exp_fir[k*DW +: DW] = ((255 + k) % 2) ? 16'h7FFF : 16'h8000;
        check("wrap_fir", fir_coeffs, exp_fir);
        check("sign_tap0", W'($signed(fir_coeffs[DW-1:0]) == 16'sh7FFF), W'(1));
        check("sign_tap1", W'($signed(fir_coeffs[2*DW-1:DW]) < 0), W'(1));

        check("pub_q_drained", W'(pub_q.size()), W'(0));
        check("err_q_drained", W'(err_q.size()), W'(0));
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
